// File: rtl/mt9v034_i2c_dri_if.sv
// Sequencer-side port bundle of the MT9V034 I2C master: request, write data and status.
// With MT9V034_I2C_READ_EN defined it also carries the read/write select and read-back data.
interface mt9v034_i2c_dri_if;
  logic        i2c_exec;
  logic [7:0]  i2c_addr;
  logic [15:0] i2c_wr_data;
  logic        i2c_done;
  logic        i2c_ack;
  logic        i2c_busy;
`ifdef MT9V034_I2C_READ_EN
  logic        i2c_rh_wl;
  logic [15:0] i2c_rd_data;

  modport master (
    output i2c_exec, i2c_addr, i2c_wr_data, i2c_rh_wl,
    input  i2c_done, i2c_ack, i2c_busy, i2c_rd_data
  );
  modport slave (
    input  i2c_exec, i2c_addr, i2c_wr_data, i2c_rh_wl,
    output i2c_done, i2c_ack, i2c_busy, i2c_rd_data
  );
`else
  modport master (
    output i2c_exec, i2c_addr, i2c_wr_data,
    input  i2c_done, i2c_ack, i2c_busy
  );
  modport slave (
    input  i2c_exec, i2c_addr, i2c_wr_data,
    output i2c_done, i2c_ack, i2c_busy
  );
`endif
endinterface

// File: rtl/mt9v034_i2c_dri.sv
// MT9V034 I2C master: start, SLAVE_ADDR+W, register byte, 16-bit data MSB first, stop.
// Define MT9V034_I2C_READ_EN to add reads (repeated start, SLAVE_ADDR+R, two data bytes in).
module mt9v034_i2c_dri #(
  parameter logic [6:0] SLAVE_ADDR = 7'h48,
  parameter int         CLK_FREQ   = 50_000_000,
  parameter int         I2C_FREQ   = 250_000
) (
  input  logic              clk,
  input  logic              rst,
  mt9v034_i2c_dri_if.slave  cfg,
  output logic              scl,
  output logic              sda_out,
  output logic              sda_oe,
  input  logic              sda_in
);

  localparam int DIV = CLK_FREQ / (4 * I2C_FREQ);
  localparam int CW  = (DIV >= 2) ? $clog2(DIV) : 1;

  if (DIV < 2) begin : g_div_check
    $error("mt9v034_i2c_dri: CLK_FREQ/(4*I2C_FREQ) must be at least 2");
  end

  typedef enum logic [3:0] {
    IDLE,
    START,
    SLV,
    REG,
    DATH,
    DATL,
    STOP
`ifdef MT9V034_I2C_READ_EN
    ,
    RSTART,
    SLVR
`endif
  } state_t;

  state_t        state_q, state_d;
  state_t        byte_next;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    qtr_q, qtr_d;
  logic [3:0]    bit_q, bit_d;
  logic [7:0]    addr_q, addr_d;
  logic [15:0]   data_q, data_d;
  logic          smp_q, smp_d;
  logic          done_q, done_d;
  logic          ack_q, ack_d;
  logic          busy_q, busy_d;
  logic          scl_q, scl_d;
  logic          sda_out_q, sda_out_d;
  logic          sda_oe_q, sda_oe_d;
  logic          q_end;
  logic          rx_now, rx_next;
  logic [7:0]    tx_byte;
  logic [2:0]    bit_sel;
`ifdef MT9V034_I2C_READ_EN
  logic          rd_q, rd_d;
  logic [15:0]   rd_shift_q, rd_shift_d;
  logic [15:0]   rd_data_q, rd_data_d;

  assign rx_now  = rd_q && ((state_q == DATH) || (state_q == DATL));
  assign rx_next = rd_d && ((state_d == DATH) || (state_d == DATL));
`else
  assign rx_now  = 1'b0;
  assign rx_next = 1'b0;
`endif

  // Byte that follows a successfully acknowledged byte state.
  always_comb begin
    byte_next = STOP;
    case (state_q)
      SLV:     byte_next = REG;
`ifdef MT9V034_I2C_READ_EN
      REG:     byte_next = rd_q ? RSTART : DATH;
      SLVR:    byte_next = DATH;
`else
      REG:     byte_next = DATH;
`endif
      DATH:    byte_next = DATL;
      default: byte_next = STOP;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    qtr_d   = qtr_q;
    bit_d   = bit_q;
    addr_d  = addr_q;
    data_d  = data_q;
    smp_d   = smp_q;
    done_d  = 1'b0;
    ack_d   = ack_q;
    busy_d  = busy_q;
`ifdef MT9V034_I2C_READ_EN
    rd_d       = rd_q;
    rd_shift_d = rd_shift_q;
    rd_data_d  = rd_data_q;
`endif
    q_end = (cnt_q == CW'(DIV - 1));

    if (state_q == IDLE) begin
      // done_q holds off a new request until the cycle after the done pulse
      if (cfg.i2c_exec && !done_q) begin
        state_d = START;
        cnt_d   = '0;
        qtr_d   = '0;
        bit_d   = '0;
        addr_d  = cfg.i2c_addr;
        data_d  = cfg.i2c_wr_data;
        busy_d  = 1'b1;
        ack_d   = 1'b0;
`ifdef MT9V034_I2C_READ_EN
        rd_d    = cfg.i2c_rh_wl;
`endif
      end
    end else begin
      if (q_end) begin
        cnt_d = '0;
        qtr_d = qtr_q + 2'd1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end

      if (q_end && (qtr_q == 2'd2)) begin
        smp_d = sda_in;
      end

      if (q_end && (qtr_q == 2'd3)) begin
        case (state_q)
          START: state_d = SLV;
`ifdef MT9V034_I2C_READ_EN
          RSTART: state_d = SLVR;
`endif
          STOP: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
`ifdef MT9V034_I2C_READ_EN
            if (rd_q && !ack_q) begin
              rd_data_d = rd_shift_q;
            end
`endif
          end
          default: begin
            if (bit_q != 4'd8) begin
              bit_d = bit_q + 4'd1;
`ifdef MT9V034_I2C_READ_EN
              if (rx_now) begin
                rd_shift_d = {rd_shift_q[14:0], smp_q};
              end
`endif
            end else begin
              bit_d = '0;
              // Slave NACK on a byte we transmitted aborts straight to STOP
              if (!rx_now && smp_q) begin
                ack_d   = 1'b1;
                state_d = STOP;
              end else begin
                state_d = byte_next;
              end
            end
          end
        endcase
      end
    end
  end

  // Pad values are decoded from the next state so they register in step with it.
  always_comb begin
    scl_d     = 1'b1;
    sda_out_d = 1'b1;
    sda_oe_d  = 1'b0;
    bit_sel   = 3'd7 - bit_d[2:0];
    tx_byte   = 8'h00;

    case (state_d)
      SLV:     tx_byte = {SLAVE_ADDR, 1'b0};
      REG:     tx_byte = addr_d;
      DATH:    tx_byte = data_d[15:8];
      DATL:    tx_byte = data_d[7:0];
`ifdef MT9V034_I2C_READ_EN
      SLVR:    tx_byte = {SLAVE_ADDR, 1'b1};
`endif
      default: tx_byte = 8'h00;
    endcase

    case (state_d)
      IDLE: begin
        scl_d     = 1'b1;
        sda_out_d = 1'b1;
        sda_oe_d  = 1'b0;
      end
`ifdef MT9V034_I2C_READ_EN
      START, RSTART: begin
`else
      START: begin
`endif
        sda_oe_d  = 1'b1;
        sda_out_d = !qtr_d[1];
        scl_d     = (qtr_d != 2'd3);
      end
      STOP: begin
        sda_oe_d  = 1'b1;
        sda_out_d = qtr_d[1];
        scl_d     = (qtr_d != 2'd0);
      end
      default: begin
        scl_d = (qtr_d == 2'd1) || (qtr_d == 2'd2);
        if (rx_next) begin
          // Master ACKs the high data byte and leaves the low one NACKed
          if ((bit_d == 4'd8) && (state_d == DATH)) begin
            sda_oe_d  = 1'b1;
            sda_out_d = 1'b0;
          end
        end else if (bit_d != 4'd8) begin
          sda_oe_d  = 1'b1;
          sda_out_d = tx_byte[bit_sel];
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      qtr_q     <= '0;
      bit_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      smp_q     <= 1'b0;
      done_q    <= 1'b0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      scl_q     <= 1'b1;
      sda_out_q <= 1'b1;
      sda_oe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      qtr_q     <= qtr_d;
      bit_q     <= bit_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      smp_q     <= smp_d;
      done_q    <= done_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      scl_q     <= scl_d;
      sda_out_q <= sda_out_d;
      sda_oe_q  <= sda_oe_d;
    end
  end

`ifdef MT9V034_I2C_READ_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q       <= 1'b0;
      rd_shift_q <= '0;
      rd_data_q  <= '0;
    end else begin
      rd_q       <= rd_d;
      rd_shift_q <= rd_shift_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign cfg.i2c_rd_data = rd_data_q;
`endif

  assign cfg.i2c_done = done_q;
  assign cfg.i2c_ack  = ack_q;
  assign cfg.i2c_busy = busy_q;
  assign scl          = scl_q;
  assign sda_out      = sda_out_q;
  assign sda_oe       = sda_oe_q;

endmodule

// File: tb/tb_mt9v034_i2c_dri.sv
// Bench for mt9v034_i2c_dri: open-drain slave/bus monitor plus vector table and directed sequences.
`timescale 1ns/1ps
module tb_mt9v034_i2c_dri;

  logic clk = 1'b0;
  logic rst;
  always #10 clk = ~clk;

  mt9v034_i2c_dri_if bus ();
  logic scl, sda_out, sda_oe, sda_in, sda_line;
  logic slave_low;

  assign sda_line = (sda_oe ? sda_out : 1'b1) & ~slave_low;
  assign sda_in   = sda_line;

  mt9v034_i2c_dri dut (
    .clk     (clk),
    .rst     (rst),
    .cfg     (bus),
    .scl     (scl),
    .sda_out (sda_out),
    .sda_oe  (sda_oe),
    .sda_in  (sda_in)
  );

  int total = 0;
  int bad   = 0;

  // Bus monitor and slave model
  logic [7:0]  mon_q[$];
  int          starts = 0, stops = 0, done_cnt = 0;
  int          bitcnt = 0, txn_byte = 0, frame_byte = 0;
  int          nack_at;
  logic [15:0] rd_word;
  logic [7:0]  sr;
  logic        rd_mode, prev_scl, prev_sda, line;

  always @(negedge clk) begin
    if (rst) begin
      bitcnt = 0; txn_byte = 0; frame_byte = 0; rd_mode = 1'b0;
      slave_low = 1'b0; prev_scl = 1'b1; prev_sda = 1'b1;
    end else begin
      line = (sda_oe ? sda_out : 1'b1) & ~slave_low;
      if (bus.i2c_done) done_cnt++;
      if (scl && prev_scl && prev_sda && !line) begin
        starts++; bitcnt = 0; frame_byte = 0; rd_mode = 1'b0;
      end else if (scl && prev_scl && !prev_sda && line) begin
        stops++; bitcnt = 0; txn_byte = 0; frame_byte = 0; rd_mode = 1'b0;
      end else if (scl && !prev_scl) begin
        if (bitcnt < 8) sr = {sr[6:0], line};
        if (bitcnt == 7) begin
          mon_q.push_back(sr);
          txn_byte++;
          if (frame_byte == 0 && sr[0]) rd_mode = 1'b1;
          frame_byte++;
        end
        bitcnt = (bitcnt == 8) ? 0 : bitcnt + 1;
      end else if (!scl && prev_scl) begin
        if (bitcnt == 8)
          slave_low = !(rd_mode && frame_byte >= 2) && (txn_byte != nack_at);
        else if (rd_mode && (frame_byte == 1 || frame_byte == 2))
          slave_low = !rd_word[15 - (frame_byte - 1) * 8 - bitcnt];
        else
          slave_low = 1'b0;
      end
      prev_scl = scl;
      prev_sda = (sda_oe ? sda_out : 1'b1) & ~slave_low;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  int   t_lat;
  logic t_ack, t_busy, t_pulse, t_idle;

  // Called at a negedge; returns at the negedge after the done cycle.
  task automatic run_txn(input logic [7:0] a, input logic [15:0] d, input int spam_at);
    int n;
    bus.i2c_exec = 1'b1; bus.i2c_addr = a; bus.i2c_wr_data = d;
    @(posedge clk);
    @(negedge clk);
    bus.i2c_exec = 1'b0;
    t_busy = bus.i2c_busy;
    t_lat = -1; t_ack = 1'bx; t_idle = 1'b0; n = 0;
    while (n < 20000) begin
      if (n == spam_at) begin
        bus.i2c_exec = 1'b1; bus.i2c_addr = 8'h04; bus.i2c_wr_data = 16'h0280;
      end
      @(posedge clk);
      n++;
      @(negedge clk);
      bus.i2c_exec = 1'b0;
      if (bus.i2c_done) begin
        t_lat = n; t_ack = bus.i2c_ack; t_idle = !bus.i2c_busy;
        break;
      end
    end
    @(negedge clk);
    t_pulse = !bus.i2c_done;
  endtask

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
    logic [2:0]  nack_at;
    logic [15:0] lat;
    logic        ack;
    logic [2:0]  nb;
    logic [31:0] bytes;
  } vec_t;

  vec_t vecs[5];
  int   base, s0, d0, st0;
  logic [31:0] exp8;

  initial begin
    vecs[0] = '{8'h03, 16'h01E0, 3'd0, 16'd7600, 1'b0, 3'd4, 32'h900301E0};
    vecs[1] = '{8'hAA, 16'h55C3, 3'd3, 16'd5800, 1'b1, 3'd3, 32'h90AA5500};
    vecs[2] = '{8'h03, 16'h01E0, 3'd1, 16'd2200, 1'b1, 3'd1, 32'h90000000};
    vecs[3] = '{8'h7F, 16'h1234, 3'd2, 16'd4000, 1'b1, 3'd2, 32'h907F0000};
    vecs[4] = '{8'h10, 16'hBEEF, 3'd4, 16'd7600, 1'b1, 3'd4, 32'h9010BEEF};

    rst = 1'b1; nack_at = 0; rd_word = 16'h0000;
    bus.i2c_exec = 1'b0; bus.i2c_addr = 8'h00; bus.i2c_wr_data = 16'h0000;
`ifdef MT9V034_I2C_READ_EN
    bus.i2c_rh_wl = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_scl", 32'(scl), 32'd1);
    chk("rst_sda_out", 32'(sda_out), 32'd1);
    chk("rst_sda_oe", 32'(sda_oe), 32'd0);
    chk("rst_done", 32'(bus.i2c_done), 32'd0);
    chk("rst_ack", 32'(bus.i2c_ack), 32'd0);
    chk("rst_busy", 32'(bus.i2c_busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      nack_at = int'(vecs[i].nack_at);
      base = mon_q.size(); s0 = stops; d0 = done_cnt;
      run_txn(vecs[i].addr, vecs[i].data, -1);
      chk($sformatf("v%0d_lat", i), 32'(t_lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d_ack", i), 32'(t_ack), 32'(vecs[i].ack));
      chk($sformatf("v%0d_busy", i), 32'(t_busy), 32'd1);
      chk($sformatf("v%0d_idle_at_done", i), 32'(t_idle), 32'd1);
      chk($sformatf("v%0d_pulse1", i), 32'(t_pulse), 32'd1);
      chk($sformatf("v%0d_nbytes", i), 32'(mon_q.size() - base), 32'(vecs[i].nb));
      for (int j = 0; j < int'(vecs[i].nb); j++) begin
        exp8 = vecs[i].bytes >> (24 - 8 * j);
        chk($sformatf("v%0d_byte%0d", i, j), 32'(mon_q[base + j]), 32'(exp8[7:0]));
      end
      chk($sformatf("v%0d_stops", i), 32'(stops - s0), 32'd1);
      chk($sformatf("v%0d_dones", i), 32'(done_cnt - d0), 32'd1);
    end
    nack_at = 0;

    // Exec while busy must be dropped.
    base = mon_q.size(); d0 = done_cnt;
    run_txn(8'h03, 16'h01E0, 100);
    chk("busy_ex_lat", 32'(t_lat), 32'd7600);
    chk("busy_ex_ack", 32'(t_ack), 32'd0);
    chk("busy_ex_nbytes", 32'(mon_q.size() - base), 32'd4);
    chk("busy_ex_bytes", {mon_q[base], mon_q[base+1], mon_q[base+2], mon_q[base+3]}, 32'h900301E0);
    repeat (20) @(negedge clk);
    chk("busy_ex_dones", 32'(done_cnt - d0), 32'd1);
    chk("busy_ex_idle", 32'(bus.i2c_busy), 32'd0);

    // Back-to-back: second exec in the cycle right after the done pulse.
    base = mon_q.size();
    run_txn(8'h03, 16'h01E0, -1);
    chk("b2b_lat0", 32'(t_lat), 32'd7600);
    run_txn(8'h04, 16'h0280, -1);
    chk("b2b_busy1", 32'(t_busy), 32'd1);
    chk("b2b_lat1", 32'(t_lat), 32'd7600);
    chk("b2b_bytes0", {mon_q[base], mon_q[base+1], mon_q[base+2], mon_q[base+3]}, 32'h900301E0);
    chk("b2b_bytes1", {mon_q[base+4], mon_q[base+5], mon_q[base+6], mon_q[base+7]}, 32'h90040280);

    // Reset in the middle of a transfer.
    d0 = done_cnt;
    bus.i2c_exec = 1'b1; bus.i2c_addr = 8'h03; bus.i2c_wr_data = 16'h01E0;
    @(posedge clk);
    @(negedge clk);
    bus.i2c_exec = 1'b0;
    repeat (2999) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_scl", 32'(scl), 32'd1);
    chk("midrst_sda_oe", 32'(sda_oe), 32'd0);
    chk("midrst_busy", 32'(bus.i2c_busy), 32'd0);
    chk("midrst_done", 32'(bus.i2c_done), 32'd0);
    rst = 1'b0;
    repeat (5000) @(negedge clk);
    chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    base = mon_q.size(); s0 = stops;
    run_txn(8'h55, 16'hA5A5, -1);
    chk("postrst_lat", 32'(t_lat), 32'd7600);
    chk("postrst_bytes", {mon_q[base], mon_q[base+1], mon_q[base+2], mon_q[base+3]}, 32'h9055A5A5);
    chk("postrst_stops", 32'(stops - s0), 32'd1);

`ifdef MT9V034_I2C_READ_EN
    base = mon_q.size(); st0 = starts;
    rd_word = 16'h1324; bus.i2c_rh_wl = 1'b1;
    run_txn(8'h00, 16'h0000, -1);
    bus.i2c_rh_wl = 1'b0;
    chk("rd_lat", 32'(t_lat), 32'd9600);
    chk("rd_ack", 32'(t_ack), 32'd0);
    chk("rd_starts", 32'(starts - st0), 32'd2);
    chk("rd_addr_bytes", {8'h00, mon_q[base], mon_q[base+1], mon_q[base+2]}, 32'h00900091);
    chk("rd_data", 32'(bus.i2c_rd_data), 32'h1324);
`else
    st0 = 0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
